i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter: DEV_ADDR, default 7'h40, 7-bit target address this block responds to.
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth for scl_in/sda_in.
REQ-003 clk  input  1  single system clock, all logic posedge clk; minimum 8x SCL rate.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 scl_in  input  1  I2C SCL line as seen at the pin, asynchronous.
REQ-006 sda_in  input  1  I2C SDA line as seen at the pin, asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 wr_valid  output  1  one-clk pulse per data byte written into the register file.
REQ-009 wr_addr  output  4  register index of the write flagged by wr_valid.
REQ-010 wr_data  output  8  byte written, valid with wr_valid.
REQ-011 busy  output  1  high from addressed START until STOP/NACK-release.

Function
REQ-012 Internal 16x8 register file, 4-bit pointer ptr; all 16 registers readable and writable over I2C.
REQ-013 START = sync SDA falling while sync SCL high; STOP = sync SDA rising while sync SCL high; both recognised in every state, including mid-byte.
REQ-014 Bits sampled on sync SCL rising edge, MSB first; sda_oe changes only on the clk after a sync SCL falling edge.
REQ-015 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, RX, RX_ACK, TX, TX_ACK.
REQ-016 IDLE -> ADDR on START; bit counter loads 7.
REQ-017 ADDR: shift 8 bits (7 address + R/W); on match with DEV_ADDR -> ADDR_ACK, else -> IDLE with sda_oe = 0 until next START.
REQ-018 ADDR_ACK: sda_oe = 1 for one SCL period; then R/W = 0 -> PTR, R/W = 1 -> TX with register[ptr] loaded to shift register.
REQ-019 PTR: receive 8 bits; ptr <= byte[3:0] (upper nibble ignored); ACK in PTR_ACK; then -> RX.
REQ-020 RX: receive 8 bits; in RX_ACK drive ACK, write register[ptr], pulse wr_valid with wr_addr = ptr, wr_data = byte, then ptr <= ptr + 1 mod 16 (15 wraps to 0).
REQ-021 TX: drive sda_oe = ~bit (bit 0 -> pull low, bit 1 -> release) for 8 bits; then TX_ACK releases SDA and samples master ACK.
REQ-022 TX_ACK: master ACK (SDA low) -> ptr <= ptr + 1 mod 16, reload, -> TX; master NACK -> IDLE, SDA released.
REQ-023 Repeated START in any state -> ADDR; ptr retained.
REQ-024 STOP in any state -> IDLE, sda_oe = 0, busy = 0; partial byte discarded, no write.
REQ-025 wr_valid asserted exactly one clk per completed RX byte; never for pointer byte or TX.
REQ-026 Writes to register file from I2C only; reads return the most recently written value.

Reset
REQ-027 On reset low: state = IDLE, sda_oe = 0, busy = 0, wr_valid = 0, wr_addr = 0, wr_data = 0, ptr = 0, all registers = 8'h00, synchronizers = 1 (bus idle).
REQ-028 Reset asserted mid-transfer releases SDA within the same clk (asynchronous); no partial write occurs.

Structure
REQ-029 Shared package i2c_pkg holds the state enumeration, default DEV_ADDR and register-file depth/pointer width constants.
REQ-030 One sub-module i2c_line_sync: synchronizer plus rise/fall edge detect for one line, instantiated for SCL and SDA.
REQ-031 State machine, shift register, bit counter, pointer and register file live in i2c_target.

Verification
REQ-032 Write: START, 0x80 (addr 0x40 W), 0x03, 0xA5, 0x5A, STOP -> three ACKs, wr_valid pulses with (3, A5) then (4, 5A); reg3 = A5, reg4 = 5A.
REQ-033 Read: START 0x80, 0x03, repeated START 0x81, master ACK, NACK -> target returns A5 then 5A, releases SDA after NACK, busy = 0 after STOP.
REQ-034 Wrong address: START 0x82 -> no ACK (sda_oe = 0 throughout), no wr_valid, state IDLE.
REQ-035 Wrap: pointer 0x0F, write 0x11, 0x22 -> reg15 = 11, reg0 = 22, wr_addr sequence 15, 0.
REQ-036 Abort: STOP after 4 data bits of RX -> no wr_valid, register unchanged, IDLE; then a full write succeeds.
REQ-037 Reset low during TX bit driving 0 -> sda_oe = 0 at once, all outputs at REQ-027 values, registers = 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-file target: FSM states,
// default device address and register-file geometry.
package i2c_pkg;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h40;
    localparam int         REG_DEPTH        = 16;
    localparam int         PTR_W            = 4;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_RX       = 4'd5,
        ST_RX_ACK   = 4'd6,
        ST_TX       = 4'd7,
        ST_TX_ACK   = 4'd8
    } i2c_state_e;

    // Register pointer advance; wraps from the last register back to 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer and edge detector for one open-drain bus line; all outputs
// registered so level and edge flags for SCL and SDA stay cycle-aligned.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   level_r;
    logic                   rise_r;
    logic                   fall_r;

    // Synchronizer chain plus registered level/edge flags; idle bus reads high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r  <= {SYNC_STAGES{1'b1}};
            level_r <= 1'b1;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync_r[0] <= line;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            level_r <= sync_r[SYNC_STAGES-1];
            rise_r  <= sync_r[SYNC_STAGES-1] & ~level_r;
            fall_r  <= ~sync_r[SYNC_STAGES-1] & level_r;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a 16x8 register file: pointer byte after the address,
// then sequential writes or reads with pointer auto-increment.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    logic scl_s, scl_rise_s, scl_fall_s;
    logic sda_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .line  (scl_in),
        .level (scl_s),
        .rise  (scl_rise_s),
        .fall  (scl_fall_s)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .line  (sda_in),
        .level (sda_s),
        .rise  (sda_rise_s),
        .fall  (sda_fall_s)
    );

    assign start_s = sda_fall_s & scl_s;
    assign stop_s  = sda_rise_s & scl_s;

    i2c_state_e       state_r, state_nxt;
    logic [2:0]       bit_cnt_r, bit_cnt_nxt;
    logic [7:0]       shift_r, shift_nxt;
    logic [PTR_W-1:0] ptr_r, ptr_nxt;
    logic             phase_r, phase_nxt;
    logic             ack_r, ack_nxt;
    logic             busy_r, busy_nxt;
    logic [7:0]       regs_r [REG_DEPTH];

    logic             sda_oe_r, sda_oe_nxt;
    logic             wr_valid_r, wr_valid_nxt;
    logic [3:0]       wr_addr_r, wr_addr_nxt;
    logic [7:0]       wr_data_r, wr_data_nxt;
    logic             reg_we_s;

    logic [7:0]       byte_in_s;
    logic [PTR_W-1:0] ptr_inc_s;

    assign byte_in_s = {shift_r[6:0], sda_s};
    assign ptr_inc_s = ptr_inc(ptr_r);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            ptr_r     <= {PTR_W{1'b0}};
            phase_r   <= 1'b0;
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            shift_r   <= shift_nxt;
            ptr_r     <= ptr_nxt;
            phase_r   <= phase_nxt;
            ack_r     <= ack_nxt;
            busy_r    <= busy_nxt;
        end
    end

    // Next-state and datapath update; START/STOP override every state.
    // phase_r marks the second half of an ACK slot (ACK already driven).
    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        shift_nxt   = shift_r;
        ptr_nxt     = ptr_r;
        phase_nxt   = phase_r;
        ack_nxt     = ack_r;
        busy_nxt    = busy_r;
        if (stop_s) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            phase_nxt = 1'b0;
        end else if (start_s) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = 3'd7;
            phase_nxt   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_nxt = 1'b0;
                end
                ST_ADDR, ST_PTR, ST_RX: begin
                    if (scl_rise_s) begin
                        shift_nxt = byte_in_s;
                        if (bit_cnt_r == 3'd0) begin
                            phase_nxt = 1'b0;
                            case (state_r)
                                ST_ADDR: begin
                                    if (byte_in_s[7:1] == DEV_ADDR) begin
                                        state_nxt = ST_ADDR_ACK;
                                        busy_nxt  = 1'b1;
                                    end else begin
                                        state_nxt = ST_IDLE;
                                        busy_nxt  = 1'b0;
                                    end
                                end
                                ST_PTR: begin
                                    state_nxt = ST_PTR_ACK;
                                    ptr_nxt   = byte_in_s[PTR_W-1:0];
                                end
                                default: state_nxt = ST_RX_ACK;
                            endcase
                        end else begin
                            bit_cnt_nxt = bit_cnt_r - 3'd1;
                        end
                    end else begin
                        shift_nxt = shift_r;
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_RX_ACK: begin
                    if (scl_fall_s) begin
                        if (!phase_r) begin
                            phase_nxt = 1'b1;
                            if (state_r == ST_RX_ACK) begin
                                ptr_nxt = ptr_inc_s;
                            end else begin
                                ptr_nxt = ptr_r;
                            end
                        end else begin
                            phase_nxt   = 1'b0;
                            bit_cnt_nxt = 3'd7;
                            if (state_r == ST_ADDR_ACK && shift_r[0]) begin
                                state_nxt = ST_TX;
                                shift_nxt = regs_r[ptr_r];
                            end else if (state_r == ST_ADDR_ACK) begin
                                state_nxt = ST_PTR;
                            end else begin
                                state_nxt = ST_RX;
                            end
                        end
                    end else begin
                        phase_nxt = phase_r;
                    end
                end
                ST_TX: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_r == 3'd0) begin
                            state_nxt = ST_TX_ACK;
                            ack_nxt   = 1'b0;
                        end else begin
                            bit_cnt_nxt = bit_cnt_r - 3'd1;
                            shift_nxt   = {shift_r[6:0], 1'b0};
                        end
                    end else begin
                        shift_nxt = shift_r;
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise_s) begin
                        ack_nxt = ~sda_s;
                    end else if (scl_fall_s) begin
                        if (ack_r) begin
                            state_nxt   = ST_TX;
                            ptr_nxt     = ptr_inc_s;
                            shift_nxt   = regs_r[ptr_inc_s];
                            bit_cnt_nxt = 3'd7;
                        end else begin
                            state_nxt = ST_IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        ack_nxt = ack_r;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Next values of the registered outputs; SDA only moves after SCL falls.
    always_comb begin
        sda_oe_nxt   = sda_oe_r;
        wr_valid_nxt = 1'b0;
        wr_addr_nxt  = wr_addr_r;
        wr_data_nxt  = wr_data_r;
        reg_we_s     = 1'b0;
        if (stop_s || start_s) begin
            sda_oe_nxt = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        if (!phase_r) begin
                            sda_oe_nxt = 1'b1;
                        end else if (shift_r[0]) begin
                            sda_oe_nxt = ~regs_r[ptr_r][7];
                        end else begin
                            sda_oe_nxt = 1'b0;
                        end
                    end else begin
                        sda_oe_nxt = sda_oe_r;
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_nxt = ~phase_r;
                    end else begin
                        sda_oe_nxt = sda_oe_r;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall_s && !phase_r) begin
                        sda_oe_nxt   = 1'b1;
                        reg_we_s     = 1'b1;
                        wr_valid_nxt = 1'b1;
                        wr_addr_nxt  = ptr_r;
                        wr_data_nxt  = shift_r;
                    end else if (scl_fall_s) begin
                        sda_oe_nxt = 1'b0;
                    end else begin
                        sda_oe_nxt = sda_oe_r;
                    end
                end
                ST_TX: begin
                    if (scl_fall_s) begin
                        sda_oe_nxt = (bit_cnt_r == 3'd0) ? 1'b0 : ~shift_r[6];
                    end else begin
                        sda_oe_nxt = sda_oe_r;
                    end
                end
                ST_TX_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_nxt = ack_r ? ~regs_r[ptr_inc_s][7] : 1'b0;
                    end else begin
                        sda_oe_nxt = sda_oe_r;
                    end
                end
                default: begin
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Output registers; the async reset releases SDA immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sda_oe_r   <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= 4'd0;
            wr_data_r  <= 8'h00;
        end else begin
            sda_oe_r   <= sda_oe_nxt;
            wr_valid_r <= wr_valid_nxt;
            wr_addr_r  <= wr_addr_nxt;
            wr_data_r  <= wr_data_nxt;
        end
    end

    // Register file, written only by completed RX bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (reg_we_s) begin
            regs_r[ptr_r] <= shift_r;
        end else begin
            regs_r[ptr_r] <= regs_r[ptr_r];
        end
    end

    assign sda_oe   = sda_oe_r;
    assign wr_valid = wr_valid_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged bus master, a table of write /
// read-back vectors, and hand sequences for wrap, abort and reset corners.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          oe_cnt = 0;
    logic [11:0] wr_log [0:255];

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_log[wr_cnt[7:0]] = {wr_addr, wr_data};
            wr_cnt = wr_cnt + 1;
        end
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic qwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait(Q);
        scl_m = 1'b1; qwait(Q);
        sda_m = 1'b0; qwait(Q);
        scl_m = 1'b0; qwait(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait(Q);
        scl_m = 1'b1; qwait(Q);
        sda_m = 1'b1; qwait(2*Q);
    endtask

    task automatic clk_bit(input logic b, output logic smp);
        sda_m = b;    qwait(Q);
        scl_m = 1'b1; qwait(Q);
        smp = sda_line; qwait(Q);
        scl_m = 1'b0; qwait(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
        clk_bit(1'b1, d);
        ack = ~d;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, d);
            b[i] = d;
        end
        clk_bit(~mack, d);
    endtask

    task automatic read_reg(input logic [3:0] p, output logic [7:0] v);
        logic a;
        bus_start();
        wr_byte(8'h80, a);
        wr_byte({4'h0, p}, a);
        bus_start();
        wr_byte(8'h81, a);
        rd_byte(1'b0, v);
        bus_stop();
    endtask

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] ptr_b;
        logic [7:0] data;
        logic       exp_ack;
        logic [3:0] exp_addr;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic       a0, a1, a2, a3, d;
        logic [7:0] b0, b1, v;
        int         wb, ob, n;

        vt[0] = '{8'h80, 8'h07, 8'h3C, 1'b1, 4'd7};
        vt[1] = '{8'h80, 8'hF9, 8'hC3, 1'b1, 4'd9};
        vt[2] = '{8'h82, 8'h01, 8'h77, 1'b0, 4'd0};
        vt[3] = '{8'h00, 8'h02, 8'h11, 1'b0, 4'd0};
        vt[4] = '{8'h80, 8'h00, 8'hFF, 1'b1, 4'd0};
        vt[5] = '{8'hC0, 8'h00, 8'h00, 1'b0, 4'd0};
        vt[6] = '{8'h80, 8'h0A, 8'h00, 1'b1, 4'd10};

        reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        qwait(5);
        chk("reset outputs during", {sda_oe, busy, wr_valid, wr_addr, wr_data}, 32'd0);
        reset = 1'b1;
        qwait(5);
        chk("reset outputs after", {sda_oe, busy, wr_valid, wr_addr, wr_data}, 32'd0);

        // Basic write: pointer 3, then A5, 5A.
        wb = wr_cnt;
        bus_start();
        wr_byte(8'h80, a0); wr_byte(8'h03, a1); wr_byte(8'hA5, a2); wr_byte(8'h5A, a3);
        bus_stop();
        chk("write acks", {a0, a1, a2, a3}, 4'hF);
        chk("write pulse count", wr_cnt - wb, 2);
        chk("write pulse 0", wr_log[wb[7:0]], {4'd3, 8'hA5});
        chk("write pulse 1", wr_log[wb[7:0] + 8'd1], {4'd4, 8'h5A});

        // Read with repeated START, master ACK then NACK.
        bus_start();
        wr_byte(8'h80, a0); wr_byte(8'h03, a1);
        bus_start();
        wr_byte(8'h81, a2);
        chk("read acks", {a0, a1, a2}, 3'b111);
        chk("busy during read", busy, 1'b1);
        rd_byte(1'b1, b0);
        rd_byte(1'b0, b1);
        chk("read byte 0", b0, 8'hA5);
        chk("read byte 1", b1, 8'h5A);
        chk("sda released after nack", sda_oe, 1'b0);
        bus_stop();
        chk("busy after stop", busy, 1'b0);

        for (int i = 0; i < 7; i++) begin
            wb = wr_cnt; ob = oe_cnt;
            bus_start();
            wr_byte(vt[i].addr_b, a0); wr_byte(vt[i].ptr_b, a1); wr_byte(vt[i].data, a2);
            bus_stop();
            chk($sformatf("vec%0d acks", i), {a0, a1, a2}, {3{vt[i].exp_ack}});
            if (vt[i].exp_ack) begin
                chk($sformatf("vec%0d pulses", i), wr_cnt - wb, 1);
                chk($sformatf("vec%0d pulse", i), wr_log[wb[7:0]], {vt[i].exp_addr, vt[i].data});
                read_reg(vt[i].ptr_b[3:0], v);
                chk($sformatf("vec%0d readback", i), v, vt[i].data);
            end else begin
                chk($sformatf("vec%0d pulses", i), wr_cnt - wb, 0);
                chk($sformatf("vec%0d sda_oe", i), oe_cnt - ob, 0);
                chk($sformatf("vec%0d state", i), dut.state_r, ST_IDLE);
            end
        end

        // Pointer wrap on write and on read.
        wb = wr_cnt;
        bus_start();
        wr_byte(8'h80, a0); wr_byte(8'h0F, a1); wr_byte(8'h11, a2); wr_byte(8'h22, a3);
        bus_stop();
        chk("wrap pulses", wr_cnt - wb, 2);
        chk("wrap pulse 0", wr_log[wb[7:0]], {4'd15, 8'h11});
        chk("wrap pulse 1", wr_log[wb[7:0] + 8'd1], {4'd0, 8'h22});
        bus_start();
        wr_byte(8'h80, a0); wr_byte(8'h0F, a1);
        bus_start();
        wr_byte(8'h81, a2);
        rd_byte(1'b1, b0);
        rd_byte(1'b0, b1);
        bus_stop();
        chk("wrap read reg15", b0, 8'h11);
        chk("wrap read reg0", b1, 8'h22);

        // STOP after four data bits discards the byte.
        wb = wr_cnt;
        bus_start();
        wr_byte(8'h80, a0); wr_byte(8'h05, a1);
        clk_bit(1'b1, d); clk_bit(1'b0, d); clk_bit(1'b1, d); clk_bit(1'b0, d);
        bus_stop();
        chk("abort pulses", wr_cnt - wb, 0);
        chk("abort busy", busy, 1'b0);
        chk("abort state", dut.state_r, ST_IDLE);
        read_reg(4'd5, v);
        chk("abort reg5", v, 8'h00);
        wb = wr_cnt;
        bus_start();
        wr_byte(8'h80, a0); wr_byte(8'h05, a1); wr_byte(8'h96, a2);
        bus_stop();
        chk("post-abort pulse", wr_log[wb[7:0]], {4'd5, 8'h96});
        read_reg(4'd5, v);
        chk("post-abort reg5", v, 8'h96);

        // Reset while the target pulls SDA low for a 0 data bit (A5 bit 6).
        bus_start();
        wr_byte(8'h80, a0); wr_byte(8'h03, a1);
        bus_start();
        wr_byte(8'h81, a2);
        clk_bit(1'b1, d);
        n = 0;
        while (!sda_oe && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tx drives zero bit", sda_oe, 1'b1);
        #2 reset = 1'b0;
        #1 chk("reset releases sda", sda_oe, 1'b0);
        chk("reset outputs mid-tx", {sda_oe, busy, wr_valid, wr_addr, wr_data}, 32'd0);
        scl_m = 1'b1; sda_m = 1'b1;
        qwait(4);
        reset = 1'b1;
        qwait(4);
        read_reg(4'd3, v);
        chk("reset clears reg3", v, 8'h00);
        read_reg(4'd15, v);
        chk("reset clears reg15", v, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
